// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: framing constants and FSM state type shared by the UART framer and deframer
// Contents: FLAG/ESC/ESC_XOR bytes, default channel tags, framer_state_t, needs_esc().
package uart_frame_pkg;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ESC = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;
  localparam logic [7:0] TAG_FRAME_DEF = 8'h01;
  localparam logic [7:0] TAG_PHY_DEF = 8'h02;
  localparam logic [7:0] TAG_APP_DEF = 8'h03;
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_TAG, S_DATA, S_ESC, S_EOF} framer_state_t;
  function automatic logic needs_esc(input logic [7:0] b);
    return b == FLAG || b == ESC;
  endfunction
endpackage

// File: rtl/axi_stream_if.sv
// axi_stream_if: minimal AXI-Stream bundle (tdata/tvalid/tready/tlast)
// Modports: master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface axi_stream_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker over N requesters
// Ports: clk, rst, req[N] requests, advance commits the current pick as last grant,
//        gnt[N] one-hot pick (search starts just after the last grant; after reset ch0 first).
module rr_arbiter #(parameter int N = 3) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] last;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  // Walk from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    gnt = '0;
    pick = last;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(last) + i) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        pick = idx;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) last <= PW'(N - 1);
    else if (advance && |req) last <= pick;
endmodule

// File: rtl/uart_resp_framer.sv
// uart_resp_framer: merges three AXI-Stream sources into one escaped, tagged UART byte stream
// Ports: clk, rst (sync, active-high); rest_of_frame_axis/eth_phy_axis/app_response_axis
//        slave sources ch0/ch1/ch2; uart_out master framed stream (tlast on closing FLAG);
//        busy from grant until closing FLAG accepted; frames_sent completed-frame counter.
// Frame: FLAG, TAG, payload with 0x7E/0x7D sent as 0x7D,byte^0x20, FLAG.
module uart_resp_framer import uart_frame_pkg::*; #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] TAG_FRAME  = TAG_FRAME_DEF,
  parameter logic [7:0] TAG_PHY    = TAG_PHY_DEF,
  parameter logic [7:0] TAG_APP    = TAG_APP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  axi_stream_if.slave  rest_of_frame_axis,
  axi_stream_if.slave  eth_phy_axis,
  axi_stream_if.slave  app_response_axis,
  axi_stream_if.master uart_out,
  output logic         busy,
  output logic [15:0]  frames_sent
);
  if (DATA_WIDTH != 8) begin : g_width_check
    $error("uart_resp_framer: only DATA_WIDTH=8 is supported");
  end
  framer_state_t state, state_nxt;
  logic [2:0] req, pick_gnt, grant, rdy;
  logic [7:0] din, tag, pend, out_data, ld_data;
  logic dlast, dvalid, pend_last, out_valid, out_last;
  logic free, pick, in_hs, load, ld_last, out_hs;
  assign req = {app_response_axis.tvalid, eth_phy_axis.tvalid, rest_of_frame_axis.tvalid};
  assign free = !out_valid || uart_out.tready;
  assign out_hs = out_valid && uart_out.tready;
  // SOF is loaded straight from IDLE, so back-to-back frames lose no cycle.
  assign pick = state == S_IDLE && free && |req;
  assign in_hs = state == S_DATA && dvalid && free;
  rr_arbiter #(.N(3)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .advance(pick),
    .gnt(pick_gnt)
  );
  always_comb begin
    din = grant[0] ? rest_of_frame_axis.tdata : grant[1] ? eth_phy_axis.tdata : app_response_axis.tdata;
    dlast = grant[0] ? rest_of_frame_axis.tlast : grant[1] ? eth_phy_axis.tlast : app_response_axis.tlast;
    dvalid = |(grant & req);
    tag = grant[0] ? TAG_FRAME : grant[1] ? TAG_PHY : TAG_APP;
  end
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = pick ? S_TAG : S_IDLE;
      S_SOF: state_nxt = free ? S_TAG : S_SOF;
      S_TAG: state_nxt = free ? S_DATA : S_TAG;
      S_DATA: state_nxt = !in_hs ? S_DATA : needs_esc(din) ? S_ESC : dlast ? S_EOF : S_DATA;
      S_ESC: state_nxt = !free ? S_ESC : pend_last ? S_EOF : S_DATA;
      S_EOF: state_nxt = free ? S_IDLE : S_EOF;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    rdy = state == S_DATA && free ? grant : 3'b000;
    load = pick || in_hs || (free && (state == S_SOF || state == S_TAG || state == S_ESC || state == S_EOF));
    ld_data = state == S_TAG ? tag : state == S_DATA ? (needs_esc(din) ? ESC : din) : state == S_ESC ? pend : FLAG;
    ld_last = state == S_EOF;
  end
  assign rest_of_frame_axis.tready = rdy[0];
  assign eth_phy_axis.tready = rdy[1];
  assign app_response_axis.tready = rdy[2];
  assign uart_out.tvalid = out_valid;
  assign uart_out.tdata = out_data;
  assign uart_out.tlast = out_last;
  always_ff @(posedge clk)
    if (rst) begin
      grant <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      pend <= '0;
      pend_last <= 1'b0;
      busy <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (pick) grant <= pick_gnt;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= ld_data;
        out_last <= ld_last;
      end else if (uart_out.tready) out_valid <= 1'b0;
      if (in_hs && needs_esc(din)) begin
        pend <= din ^ ESC_XOR;
        pend_last <= dlast;
      end
      if (out_hs && out_last) frames_sent <= frames_sent + 16'd1;
      // A new grant in the same cycle as the closing FLAG keeps busy high.
      busy <= pick || (busy && !(out_hs && out_last));
    end
endmodule
